// File: rtl/register_bank.sv
`default_nettype none
// ============================================================================
// Module   : register_bank
// Purpose  : DEPTH x WIDTH CPU register file. One write port (load, increment,
//            decrement, clear) with a registered carry/borrow flag, and two
//            independent combinational read ports feeding ALU operands A/B.
// Revision : 1.0 - initial release
// ============================================================================
module register_bank #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int SEL_W = 2
) (
  input  logic             clk_cpu,
  input  logic             reset,
  input  logic             we,
  input  logic [SEL_W-1:0] wsel,
  input  logic [1:0]       wmode,
  input  logic [WIDTH-1:0] dat_in,
  input  logic [SEL_W-1:0] rsel_a,
  input  logic [SEL_W-1:0] rsel_b,
  output logic [WIDTH-1:0] dat_a,
  output logic [WIDTH-1:0] dat_b,
  output logic             carry
);

  localparam logic [1:0] c_MODE_LOAD = 2'b00;
  localparam logic [1:0] c_MODE_INC  = 2'b01;
  localparam logic [1:0] c_MODE_DEC  = 2'b10;
  localparam logic [1:0] c_MODE_CLR  = 2'b11;

  localparam logic [WIDTH:0] c_ONE = (WIDTH+1)'(1);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic             carry_q;
  logic             carry_d;

  // Next-state: only the register whose index matches wsel can change, so an
  // out-of-range wsel matches nothing and the write is silently dropped.
  always_comb begin
    regs_d  = regs_q;
    carry_d = carry_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (we && (wsel == SEL_W'(i))) begin
        case (wmode)
          c_MODE_LOAD: regs_d[i] = dat_in;
          // Extra top bit of the widened sum/difference is the carry/borrow.
          c_MODE_INC:  {carry_d, regs_d[i]} = {1'b0, regs_q[i]} + c_ONE;
          c_MODE_DEC:  {carry_d, regs_d[i]} = {1'b0, regs_q[i]} - c_ONE;
          c_MODE_CLR: begin
            regs_d[i] = '0;
            carry_d   = 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk_cpu or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      carry_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
      carry_q <= carry_d;
    end
  end

  // Read ports: pure mux of current contents (no write bypass); indices
  // beyond DEPTH read as zero.
  always_comb begin
    dat_a = '0;
    dat_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rsel_a == SEL_W'(i)) dat_a = regs_q[i];
      if (rsel_b == SEL_W'(i)) dat_b = regs_q[i];
    end
  end

  assign carry = carry_q;

endmodule
`default_nettype wire

// File: tb/tb_register_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_register_bank
// Purpose  : Directed self-checking bench for register_bank: default build
//            (4x4), a DEPTH=3 build for out-of-range access, and an 8x8 build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_register_bank;

  logic clk_cpu = 1'b0;
  logic reset   = 1'b0;

  // Default build 4 bits x 4 regs
  logic       we = 1'b0;
  logic [1:0] wsel = '0, wmode = '0, rsel_a = '0, rsel_b = '0;
  logic [3:0] dat_in = '0;
  logic [3:0] dat_a, dat_b;
  logic       carry;

  // DEPTH=3 build
  logic       we3 = 1'b0;
  logic [1:0] wsel3 = '0, wmode3 = '0, rsel_a3 = '0, rsel_b3 = '0;
  logic [3:0] dat_in3 = '0;
  logic [3:0] dat_a3, dat_b3;
  logic       carry3;

  // 8 bits x 8 regs build
  logic       we8 = 1'b0;
  logic [2:0] wsel8 = '0, rsel_a8 = '0, rsel_b8 = '0;
  logic [1:0] wmode8 = '0;
  logic [7:0] dat_in8 = '0;
  logic [7:0] dat_a8, dat_b8;
  logic       carry8;

  int checks   = 0;
  int failures = 0;

  register_bank #(.WIDTH(4), .DEPTH(4), .SEL_W(2)) u_dut (
    .clk_cpu(clk_cpu), .reset(reset), .we(we), .wsel(wsel), .wmode(wmode),
    .dat_in(dat_in), .rsel_a(rsel_a), .rsel_b(rsel_b),
    .dat_a(dat_a), .dat_b(dat_b), .carry(carry));

  register_bank #(.WIDTH(4), .DEPTH(3), .SEL_W(2)) u_dut3 (
    .clk_cpu(clk_cpu), .reset(reset), .we(we3), .wsel(wsel3), .wmode(wmode3),
    .dat_in(dat_in3), .rsel_a(rsel_a3), .rsel_b(rsel_b3),
    .dat_a(dat_a3), .dat_b(dat_b3), .carry(carry3));

  register_bank #(.WIDTH(8), .DEPTH(8), .SEL_W(3)) u_dut8 (
    .clk_cpu(clk_cpu), .reset(reset), .we(we8), .wsel(wsel8), .wmode(wmode8),
    .dat_in(dat_in8), .rsel_a(rsel_a8), .rsel_b(rsel_b8),
    .dat_a(dat_a8), .dat_b(dat_b8), .carry(carry8));

  always #5 clk_cpu = ~clk_cpu;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One write cycle on the default build; returns 1 time unit after the edge.
  task automatic wr(input logic [1:0] sel, input logic [1:0] mode, input logic [3:0] d);
    we = 1'b1; wsel = sel; wmode = mode; dat_in = d;
    @(posedge clk_cpu); #1;
    we = 1'b0;
  endtask

  task automatic wr3(input logic [1:0] sel, input logic [1:0] mode, input logic [3:0] d);
    we3 = 1'b1; wsel3 = sel; wmode3 = mode; dat_in3 = d;
    @(posedge clk_cpu); #1;
    we3 = 1'b0;
  endtask

  task automatic wr8(input logic [2:0] sel, input logic [1:0] mode, input logic [7:0] d);
    we8 = 1'b1; wsel8 = sel; wmode8 = mode; dat_in8 = d;
    @(posedge clk_cpu); #1;
    we8 = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [1:0] sel, input logic [3:0] exp);
    rsel_a = sel; rsel_b = sel; #1;
    chk({tag, "_a"}, {4'h0, dat_a}, {4'h0, exp});
    chk({tag, "_b"}, {4'h0, dat_b}, {4'h0, exp});
  endtask

  logic [3:0] exp_v [4];
  logic [3:0] v4;
  logic [7:0] v8;

  initial begin
    // ---- reset held from time 0
    #2;
    rd("rst_r0", 2'd0, 4'h0);
    chk("rst_carry", {7'd0, carry}, 8'h00);
    @(negedge clk_cpu);
    reset = 1'b1;

    // ---- 1: asynchronous reset between edges
    for (int i = 0; i < 4; i++) wr(2'(i), 2'b00, 4'hA);
    rd("pre_rst_r3", 2'd3, 4'hA);
    reset = 1'b0; #1;
    for (int i = 0; i < 4; i++) rd("async_rst", 2'(i), 4'h0);
    chk("async_rst_carry", {7'd0, carry}, 8'h00);
    reset = 1'b1;

    // ---- 2: load and sweep all read pairs
    exp_v[0] = 4'h3; exp_v[1] = 4'h9; exp_v[2] = 4'hC; exp_v[3] = 4'h5;
    for (int i = 0; i < 4; i++) wr(2'(i), 2'b00, exp_v[i]);
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        rsel_a = 2'(a); rsel_b = 2'(b); #1;
        chk("sweep_a", {4'h0, dat_a}, {4'h0, exp_v[a]});
        chk("sweep_b", {4'h0, dat_b}, {4'h0, exp_v[b]});
      end
    end

    // ---- 3: increment wrap
    wr(2'd1, 2'b00, 4'hE);
    wr(2'd1, 2'b01, 4'h0);
    rd("inc1", 2'd1, 4'hF);
    chk("inc1_carry", {7'd0, carry}, 8'h00);
    wr(2'd1, 2'b01, 4'h0);
    rd("inc_wrap", 2'd1, 4'h0);
    chk("inc_wrap_carry", {7'd0, carry}, 8'h01);
    wr(2'd0, 2'b00, 4'h3);
    chk("load_keeps_carry", {7'd0, carry}, 8'h01);
    rd("inc_no_cross", 2'd2, 4'hC);

    // ---- 4: decrement borrow, clear
    wr(2'd2, 2'b00, 4'h1);
    wr(2'd2, 2'b10, 4'h0);
    rd("dec1", 2'd2, 4'h0);
    chk("dec1_carry", {7'd0, carry}, 8'h00);
    wr(2'd2, 2'b10, 4'h0);
    rd("dec_borrow", 2'd2, 4'hF);
    chk("dec_borrow_carry", {7'd0, carry}, 8'h01);
    wr(2'd2, 2'b11, 4'h9);
    rd("clear", 2'd2, 4'h0);
    chk("clear_carry", {7'd0, carry}, 8'h00);
    rd("dec_no_cross", 2'd3, 4'h5);

    // ---- 5: write latency, no bypass
    rsel_a = 2'd3;
    we = 1'b1; wsel = 2'd3; wmode = 2'b00; dat_in = 4'h7; #1;
    chk("timing_before", {4'h0, dat_a}, 8'h05);
    @(posedge clk_cpu); @(negedge clk_cpu);
    chk("timing_after", {4'h0, dat_a}, 8'h07);
    we = 1'b0; wmode = 2'b11;
    @(posedge clk_cpu); #1;
    chk("we0_hold", {4'h0, dat_a}, 8'h07);
    chk("we0_hold_carry", {7'd0, carry}, 8'h00);

    // ---- 6: out-of-range on DEPTH=3 build
    wr3(2'd0, 2'b00, 4'hF);
    wr3(2'd0, 2'b01, 4'h0);          // r0 wraps to 0, carry=1
    wr3(2'd1, 2'b00, 4'h2);
    wr3(2'd2, 2'b00, 4'h3);
    wr3(2'd3, 2'b00, 4'h6);
    wr3(2'd3, 2'b11, 4'h0);          // dropped clear must not touch carry
    rsel_a3 = 2'd0; rsel_b3 = 2'd1; #1;
    chk("oor_r0", {4'h0, dat_a3}, 8'h00);
    chk("oor_r1", {4'h0, dat_b3}, 8'h02);
    rsel_a3 = 2'd2; rsel_b3 = 2'd3; #1;
    chk("oor_r2", {4'h0, dat_a3}, 8'h03);
    chk("oor_read_b", {4'h0, dat_b3}, 8'h00);
    rsel_a3 = 2'd3; #1;
    chk("oor_read_a", {4'h0, dat_a3}, 8'h00);
    chk("oor_carry", {7'd0, carry3}, 8'h01);

    // ---- regression: 20 loads per register with read-back, default build
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 20; k++) begin
        v4 = 4'(r * 5 + k + 1);
        wr(2'(r), 2'b00, v4);
        rd("regr4", 2'(r), v4);
      end
    end

    // ---- regression on 8x8 build
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 20; k++) begin
        v8 = 8'(r * 37 + k + 1);
        wr8(3'(r), 2'b00, v8);
        rsel_a8 = 3'(r); rsel_b8 = 3'(r); #1;
        chk("regr8_a", dat_a8, v8);
        chk("regr8_b", dat_b8, v8);
      end
    end
    wr8(3'd5, 2'b00, 8'hFF);
    wr8(3'd5, 2'b01, 8'h00);
    rsel_a8 = 3'd5; rsel_b8 = 3'd4; #1;
    chk("w8_inc_wrap", dat_a8, 8'h00);
    chk("w8_inc_carry", {7'd0, carry8}, 8'h01);
    chk("w8_no_cross", dat_b8, 8'(4 * 37 + 20));
    wr8(3'd5, 2'b10, 8'h00);
    #1;
    chk("w8_dec_borrow", dat_a8, 8'hFF);
    chk("w8_dec_carry", {7'd0, carry8}, 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
